// File: rtl/fifo_to_axis_pkg.sv
// Shared encodings and field positions for the FIFO-to-AXI-Stream beat assembler.
// Combinational helpers only; no latency or backpressure of their own.
package fifo_to_axis_pkg;

   typedef enum logic {
      RD_TUSER = 1'b0,
      RD_PKT   = 1'b1
   } state_t;

   localparam int LANE_W  = 9;
   localparam int LANES   = 8;
   localparam int LEN_LSB = 0;
   localparam int LEN_MSB = 15;

   // A zero-length packet still occupies one beat on the wire.
   function automatic logic [15:0] beats_of(input logic [15:0] len, input int bytes_per_beat);
      int n;
      n = (int'(len) + bytes_per_beat - 1) / bytes_per_beat;
      if (n == 0) n = 1;
      return 16'(n);
   endfunction

endpackage

// File: rtl/fifo_to_axis_out_reg.sv
// One-deep AXI-Stream output register; loads in the same cycle as the beat completes.
// Holds all payload fields while tvalid && !tready; room when empty or being drained.
module fifo_to_axis_out_reg #(
   parameter int DW = 256,
   parameter int UW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sw_rst,
   input  logic          load,
   input  logic [DW-1:0] ld_dat,
   input  logic [DW/8-1:0] ld_strb,
   input  logic [UW-1:0] ld_user,
   input  logic          ld_last,
   output logic          room,
   output logic [DW-1:0] tdata,
   output logic [DW/8-1:0] tstrb,
   output logic [UW-1:0] tuser,
   output logic          tlast,
   output logic          tvalid,
   input  logic          tready
);

   assign room = !tvalid || tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tdata  <= '0;
         tstrb  <= '0;
         tuser  <= '0;
         tlast  <= 1'b0;
         tvalid <= 1'b0;
      end else if (sw_rst) begin
         tdata  <= '0;
         tstrb  <= '0;
         tuser  <= '0;
         tlast  <= 1'b0;
         tvalid <= 1'b0;
      end else if (load && room) begin
         tdata  <= ld_dat;
         tstrb  <= ld_strb;
         tuser  <= ld_user;
         tlast  <= ld_last;
         tvalid <= 1'b1;
      end else if (tready) begin
         tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_to_axis.sv
// Packs 72-bit {strb,byte} FIFO words into AXI-Stream beats; first beat of each packet is tuser.
// tvalid one cycle after the last word pop; pops stall only on the final word when the output register is full.
module fifo_to_axis
   import fifo_to_axis_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int FIFO_DATA_WIDTH      = 72
) (
   input  logic                              axi_aclk,
   input  logic                              axi_areset,
   input  logic                              sw_rst,
   input  logic [FIFO_DATA_WIDTH-1:0]        fifo_dout,
   input  logic                              fifo_empty,
   output logic                              fifo_rd_en,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast
);

   localparam int DW    = C_M_AXIS_DATA_WIDTH;
   localparam int UW    = C_M_AXIS_TUSER_WIDTH;
   localparam int WPB   = DW / 64;
   localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

   state_t           state;
   logic [IDX_W-1:0] word_idx;
   logic [DW-1:0]    asm_dat;
   logic [DW/8-1:0]  asm_strb;
   logic [UW-1:0]    tuser_q;
   logic [15:0]      beats_left;

   logic [63:0]      word_dat;
   logic [7:0]       word_strb;
   logic [DW-1:0]    beat_dat;
   logic [DW/8-1:0]  beat_strb;
   logic             last_word;
   logic             out_room;
   logic             pop;
   logic             load;

   always_comb begin
      word_dat  = '0;
      word_strb = '0;
      for (int j = 0; j < LANES; j++) begin
         word_dat[8*j +: 8] = fifo_dout[LANE_W*j +: 8];
         word_strb[j]       = fifo_dout[LANE_W*j + 8];
      end
      // The beat seen by the capture/load logic already includes the word being popped.
      beat_dat  = asm_dat;
      beat_strb = asm_strb;
      beat_dat[int'(word_idx)*64 +: 64] = word_dat;
      beat_strb[int'(word_idx)*8 +: 8]  = word_strb;
   end

   assign last_word  = (word_idx == IDX_W'(WPB - 1));
   assign pop        = !fifo_empty && !axi_areset && !sw_rst &&
                       (!last_word || state == RD_TUSER || out_room);
   assign fifo_rd_en = pop;
   assign load       = pop && last_word && state == RD_PKT;

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state      <= RD_TUSER;
         word_idx   <= '0;
         asm_dat    <= '0;
         asm_strb   <= '0;
         tuser_q    <= '0;
         beats_left <= '0;
      end else if (sw_rst) begin
         state      <= RD_TUSER;
         word_idx   <= '0;
         asm_dat    <= '0;
         asm_strb   <= '0;
         tuser_q    <= '0;
         beats_left <= '0;
      end else if (pop) begin
         asm_dat  <= beat_dat;
         asm_strb <= beat_strb;
         word_idx <= last_word ? '0 : word_idx + 1'b1;
         if (last_word) begin
            case (state)
               RD_TUSER: begin
                  tuser_q    <= beat_dat[UW-1:0];
                  beats_left <= beats_of(beat_dat[LEN_MSB:LEN_LSB], DW / 8);
                  state      <= RD_PKT;
               end
               RD_PKT: begin
                  beats_left <= beats_left - 16'd1;
                  if (beats_left == 16'd1) state <= RD_TUSER;
               end
               default: state <= RD_TUSER;
            endcase
         end
      end
   end

   fifo_to_axis_out_reg #(
      .DW (DW),
      .UW (UW)
   ) u_out_reg (
      .clk     (axi_aclk),
      .rst     (axi_areset),
      .sw_rst  (sw_rst),
      .load    (load),
      .ld_dat  (beat_dat),
      .ld_strb (beat_strb),
      .ld_user (tuser_q),
      .ld_last (beats_left == 16'd1),
      .room    (out_room),
      .tdata   (m_axis_tdata),
      .tstrb   (m_axis_tstrb),
      .tuser   (m_axis_tuser),
      .tlast   (m_axis_tlast),
      .tvalid  (m_axis_tvalid),
      .tready  (m_axis_tready)
   );

endmodule

// File: tb/tb_fifo_to_axis.sv
// Bench for fifo_to_axis: FIFO model feeds byte-level packets, received beats are compared
// against beats built directly from packet bytes and lengths.
module tb_fifo_to_axis;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int FW = 72;

   typedef struct packed {
      logic [DW-1:0]   d;
      logic [DW/8-1:0] s;
      logic [UW-1:0]   u;
      logic            l;
   } beat_t;

   logic            axi_aclk = 1'b0;
   logic            axi_areset = 1'b0;
   logic            sw_rst = 1'b0;
   logic [FW-1:0]   fifo_dout = '0;
   logic            fifo_empty = 1'b1;
   logic            fifo_rd_en;
   logic [DW-1:0]   m_axis_tdata;
   logic [DW/8-1:0] m_axis_tstrb;
   logic [UW-1:0]   m_axis_tuser;
   logic            m_axis_tvalid;
   logic            m_axis_tready = 1'b1;
   logic            m_axis_tlast;

   fifo_to_axis dut (
      .axi_aclk      (axi_aclk),
      .axi_areset    (axi_areset),
      .sw_rst        (sw_rst),
      .fifo_dout     (fifo_dout),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (fifo_rd_en),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
   );

   always #5 axi_aclk = ~axi_aclk;

   logic [FW-1:0] fifo_q[$];
   logic [FW-1:0] stage_q[$];
   beat_t         exp_q[$];
   beat_t         rx_q[$];
   int            rx_tick[$];
   int            pop_tick[$];
   int            tick_no = 0;
   int            checks = 0;
   int            errors = 0;
   int            empty_pop_viol = 0;
   bit            hold_empty = 1'b0;

   task automatic refresh_fifo();
      fifo_empty = hold_empty || (fifo_q.size() == 0);
      if (fifo_q.size() > 0) fifo_dout = fifo_q[0];
      else fifo_dout = '0;
   endtask

   // One clock: observe at the falling edge, apply pops just after the rising edge.
   task automatic tick();
      bit    do_pop;
      beat_t b;
      @(negedge axi_aclk);
      do_pop = fifo_rd_en;
      if (fifo_rd_en && fifo_empty) empty_pop_viol++;
      if (m_axis_tvalid && m_axis_tready) begin
         b.d = m_axis_tdata;
         b.s = m_axis_tstrb;
         b.u = m_axis_tuser;
         b.l = m_axis_tlast;
         rx_q.push_back(b);
         rx_tick.push_back(tick_no);
      end
      @(posedge axi_aclk);
      #1;
      if (do_pop && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
         pop_tick.push_back(tick_no);
      end
      tick_no++;
      refresh_fifo();
   endtask

   task automatic clear_logs();
      exp_q.delete();
      rx_q.delete();
      rx_tick.delete();
      pop_tick.delete();
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n && stage_q.size() > 0; i++) fifo_q.push_back(stage_q.pop_front());
      refresh_fifo();
   endtask

   task automatic wait_rx(input int n, input int budget, output bit ok);
      int c = 0;
      while (rx_q.size() < n && c < budget) begin
         tick();
         c++;
      end
      ok = (rx_q.size() >= n);
   endtask

   // Packet model: tuser beat, then ceil(len/32) beats of bytes with strobe = (index < len).
   task automatic build_pkt(input int len, input logic [UW-1:0] user);
      logic [DW-1:0] ub;
      logic [FW-1:0] wd[4];
      beat_t         e;
      int            nb;
      logic [7:0]    bt;
      ub = {$urandom(), $urandom(), $urandom(), $urandom(), user};
      for (int w = 0; w < 4; w++) begin
         for (int j = 0; j < 8; j++) wd[w][9*j +: 9] = {1'($urandom()), ub[64*w + 8*j +: 8]};
         stage_q.push_back(wd[w]);
      end
      nb = (len == 0) ? 1 : (len + 31) / 32;
      for (int b = 0; b < nb; b++) begin
         for (int i = 0; i < 32; i++) begin
            bt = 8'($urandom());
            e.d[8*i +: 8] = bt;
            e.s[i] = ((32*b + i) < len);
            wd[i/8][9*(i%8) +: 9] = {e.s[i], bt};
         end
         e.u = user;
         e.l = (b == nb - 1);
         exp_q.push_back(e);
         for (int w = 0; w < 4; w++) stage_q.push_back(wd[w]);
      end
   endtask

   task automatic test_reset();
      build_pkt(64, 128'h40);
      feed(100);
      axi_areset = 1'b1;
      #1;
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
      checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
      checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
      checks++; if (m_axis_tstrb !== '0) begin errors++; $display("FAIL reset_tstrb got %h want 0", m_axis_tstrb); end
      checks++; if (m_axis_tuser !== '0) begin errors++; $display("FAIL reset_tuser got %h want 0", m_axis_tuser); end
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
      tick();
      tick();
      fifo_q.delete();
      stage_q.delete();
      clear_logs();
      refresh_fifo();
      axi_areset = 1'b0;
      tick();
   endtask

   task automatic test_64_bytes();
      bit ok;
      clear_logs();
      m_axis_tready = 1'b1;
      build_pkt(64, 128'h40);
      feed(100);
      wait_rx(2, 100, ok);
      repeat (4) tick();
      checks++; if (!ok || rx_q.size() != 2) begin errors++; $display("FAIL p64_count got %0d want 2", rx_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL p64_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      if (rx_q.size() == 2) begin
         checks++; if (rx_q[0].s !== 32'hFFFF_FFFF || rx_q[1].s !== 32'hFFFF_FFFF) begin errors++; $display("FAIL p64_strb got %h/%h want ffffffff", rx_q[0].s, rx_q[1].s); end
         checks++; if (rx_q[0].l !== 1'b0 || rx_q[1].l !== 1'b1) begin errors++; $display("FAIL p64_tlast got %b%b want 01", rx_q[0].l, rx_q[1].l); end
         checks++; if (rx_q[0].u !== 128'h40 || rx_q[1].u !== 128'h40) begin errors++; $display("FAIL p64_tuser got %h want 40", rx_q[1].u); end
      end
      if (pop_tick.size() == 12 && rx_tick.size() > 0) begin
         checks++; if (rx_tick[0] != pop_tick[7] + 1) begin errors++; $display("FAIL p64_latency got %0d want %0d", rx_tick[0], pop_tick[7] + 1); end
         checks++; if (pop_tick[11] - pop_tick[0] != 11) begin errors++; $display("FAIL p64_throughput got span %0d want 11", pop_tick[11] - pop_tick[0]); end
      end else begin
         checks++; errors++; $display("FAIL p64_pops got %0d want 12", pop_tick.size());
      end
   endtask

   task automatic test_65_bytes();
      bit ok;
      clear_logs();
      build_pkt(65, 128'h41 | (128'h5A5A << 64));
      feed(100);
      wait_rx(3, 100, ok);
      repeat (4) tick();
      checks++; if (!ok || rx_q.size() != 3) begin errors++; $display("FAIL p65_count got %0d want 3", rx_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL p65_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      if (rx_q.size() == 3) begin
         checks++; if (rx_q[2].s !== 32'h0000_0001 || rx_q[2].l !== 1'b1) begin errors++; $display("FAIL p65_last got strb %h last %b want 00000001 1", rx_q[2].s, rx_q[2].l); end
      end
   endtask

   task automatic test_len_zero();
      bit ok;
      clear_logs();
      build_pkt(0, 128'h0);
      feed(100);
      wait_rx(1, 100, ok);
      repeat (6) tick();
      checks++; if (!ok || rx_q.size() != 1) begin errors++; $display("FAIL len0_count got %0d want 1", rx_q.size()); end
      if (rx_q.size() > 0) begin
         checks++; if (rx_q[0] !== exp_q[0] || rx_q[0].l !== 1'b1) begin errors++; $display("FAIL len0_beat got %h want %h", rx_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_tready_stall();
      bit    ok, snap;
      beat_t held, now;
      int    pops_mid;
      clear_logs();
      snap = 1'b0;
      build_pkt(128, 128'h80 | (128'hBEEF << 96));
      feed(100);
      wait_rx(1, 100, ok);
      m_axis_tready = 1'b0;
      pops_mid = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         now.d = m_axis_tdata; now.s = m_axis_tstrb; now.u = m_axis_tuser; now.l = m_axis_tlast;
         if (snap) begin
            checks++;
            if (!m_axis_tvalid || now !== held) begin errors++; $display("FAIL stall_hold c%0d got %h want %h", c, now, held); end
         end else if (m_axis_tvalid) begin
            held = now;
            snap = 1'b1;
         end
         if (c == 5) pops_mid = pop_tick.size();
      end
      checks++; if (pop_tick.size() != pops_mid || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en got pops %0d->%0d rd_en %b want no pops", pops_mid, pop_tick.size(), fifo_rd_en); end
      m_axis_tready = 1'b1;
      wait_rx(4, 100, ok);
      repeat (4) tick();
      checks++; if (!ok || rx_q.size() != 4) begin errors++; $display("FAIL stall_count got %0d want 4", rx_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_empty_pause();
      bit ok;
      int c;
      clear_logs();
      build_pkt(64, 128'h40 | (128'h77 << 32));
      feed(6);
      c = 0;
      while (fifo_q.size() > 0 && c < 50) begin tick(); c++; end
      repeat (3) tick();
      checks++; if (rx_q.size() != 0 || pop_tick.size() != 6) begin errors++; $display("FAIL pause_state got rx %0d pops %0d want 0 6", rx_q.size(), pop_tick.size()); end
      feed(100);
      wait_rx(2, 100, ok);
      repeat (4) tick();
      checks++; if (!ok || rx_q.size() != 2) begin errors++; $display("FAIL pause_count got %0d want 2", rx_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL pause_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_packet();
      bit ok;
      clear_logs();
      build_pkt(128, 128'h80);
      feed(100);
      wait_rx(1, 100, ok);
      axi_areset = 1'b1;
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, fifo_rd_en} !== 3'b000 || m_axis_tdata !== '0 ||
          m_axis_tstrb !== '0 || m_axis_tuser !== '0) begin
         errors++; $display("FAIL midrst_outputs got v%b l%b rd%b d%h want all 0", m_axis_tvalid, m_axis_tlast, fifo_rd_en, m_axis_tdata);
      end
      fifo_q.delete();
      stage_q.delete();
      refresh_fifo();
      tick();
      tick();
      axi_areset = 1'b0;
      clear_logs();
      tick();
      build_pkt(64, 128'h40 | (128'h1234 << 64));
      feed(100);
      wait_rx(2, 100, ok);
      repeat (4) tick();
      checks++; if (!ok || rx_q.size() != 2) begin errors++; $display("FAIL midrst_count got %0d want 2", rx_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random_traffic();
      int len, c;
      clear_logs();
      for (int p = 0; p < 8; p++) begin
         len = $urandom_range(0, 200);
         build_pkt(len, {$urandom(), $urandom(), $urandom(), 16'($urandom()), 16'(len)});
      end
      feed(10000);
      c = 0;
      while (rx_q.size() < exp_q.size() && c < 3000) begin
         m_axis_tready = ($urandom_range(0, 3) != 0);
         hold_empty = ($urandom_range(0, 4) == 0);
         refresh_fifo();
         tick();
         c++;
      end
      hold_empty = 1'b0;
      m_axis_tready = 1'b1;
      refresh_fifo();
      repeat (6) tick();
      checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      refresh_fifo();
      #2;
      test_reset();
      test_64_bytes();
      test_65_bytes();
      test_len_zero();
      test_tready_stall();
      test_empty_pause();
      test_reset_mid_packet();
      test_random_traffic();
      checks++; if (empty_pop_viol != 0) begin errors++; $display("FAIL pop_while_empty got %0d want 0", empty_pop_viol); end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
